// File: rtl/missile_pkg.sv
// Shared geometry defaults and slot state layout for the missile array.
package missile_pkg;

  localparam int unsigned COORD_W     = 9;
  localparam int unsigned MISSILE_W   = 2;
  localparam int unsigned MISSILE_H   = 8;
  localparam int unsigned SPEED       = 4;
  localparam int unsigned UPDATE_LINE = 240;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } slot_t;

endpackage

// File: rtl/missile_slot.sv
// One missile slot: position/active registers, launch/kill/motion, and hit test.
module missile_slot
  import missile_pkg::*;
#(
  parameter int unsigned MISSILE_W = missile_pkg::MISSILE_W,
  parameter int unsigned MISSILE_H = missile_pkg::MISSILE_H,
  parameter int unsigned SPEED     = missile_pkg::SPEED
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         kill,
  input  logic         move,
  input  logic [8:0]   load_x,
  input  logic [8:0]   load_y,
  input  logic [8:0]   hpos,
  input  logic [8:0]   vpos,
  output logic         active,
  output logic         hit_c
);

  slot_t slot_q, slot_d;

  logic [9:0] h10, v10, x_lo, x_hi, y_lo, y_hi;

  // Next slot state: kill beats load, load beats per-frame motion.
  always_comb begin
    slot_d = slot_q;
    if (kill) begin
      slot_d.active = 1'b0;
    end else if (load) begin
      slot_d.active = 1'b1;
      slot_d.x      = load_x;
      slot_d.y      = load_y;
    end else if (move && slot_q.active) begin
      if (slot_q.y < 9'(SPEED)) slot_d.active = 1'b0;
      else                      slot_d.y      = slot_q.y - 9'(SPEED);
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  // Hit test on 10-bit sums so sprites past 511 clip instead of wrapping; top row is blank.
  always_comb begin
    h10   = {1'b0, hpos};
    v10   = {1'b0, vpos};
    x_lo  = {1'b0, slot_q.x};
    x_hi  = {1'b0, slot_q.x} + 10'(MISSILE_W);
    y_lo  = {1'b0, slot_q.y} + 10'd1;
    y_hi  = {1'b0, slot_q.y} + 10'(MISSILE_H);
    hit_c = slot_q.active && (h10 >= x_lo) && (h10 < x_hi) &&
            (v10 >= y_lo) && (v10 < y_hi);
  end

  assign active = slot_q.active;

endmodule

// File: rtl/missile_array_renderer.sv
// N-slot missile renderer: launch handshake, kill, per-frame motion, pixel output.
module missile_array_renderer
  import missile_pkg::*;
#(
  parameter int unsigned N_MISSILES  = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned MISSILE_W   = missile_pkg::MISSILE_W,
  parameter int unsigned MISSILE_H   = missile_pkg::MISSILE_H,
  parameter int unsigned SPEED       = missile_pkg::SPEED,
  parameter int unsigned UPDATE_LINE = missile_pkg::UPDATE_LINE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            hpos,
  input  logic [8:0]            vpos,
  input  logic                  display_on,
  input  logic                  fire_req,
  input  logic [8:0]            fire_x,
  input  logic [8:0]            fire_y,
  output logic                  fire_ack,
  output logic                  fire_full,
  input  logic                  kill_valid,
  input  logic [IDX_W-1:0]      kill_idx,
  output logic [N_MISSILES-1:0] active_mask,
  output logic                  gfx,
  output logic [IDX_W-1:0]      gfx_idx
);

  logic [N_MISSILES-1:0] active_vec, hit_vec, load_sel, kill_sel;
  logic                  free_found, fire_go, move_c, hit_any;
  logic                  fire_ack_q, fire_ack_d, gfx_q, gfx_d;
  logic [IDX_W-1:0]      gfx_idx_q, gfx_idx_d;

  assign move_c = (hpos == 9'd0) && (vpos == 9'(UPDATE_LINE));

  // Lowest free slot gets the launch; kills only address slots that are live.
  always_comb begin
    load_sel   = '0;
    kill_sel   = '0;
    free_found = 1'b0;
    for (int i = 0; i < int'(N_MISSILES); i++) begin
      if (!active_vec[i] && !free_found) begin
        load_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
      kill_sel[i] = kill_valid && (kill_idx == IDX_W'(i)) && active_vec[i];
    end
    fire_go    = fire_req && !fire_ack_q && free_found;
    fire_ack_d = fire_go;
  end

  genvar g;
  generate
    for (g = 0; g < int'(N_MISSILES); g++) begin : g_slot
      missile_slot #(
        .MISSILE_W (MISSILE_W),
        .MISSILE_H (MISSILE_H),
        .SPEED     (SPEED)
      ) u_slot (
        .clk    (clk),
        .reset  (reset),
        .load   (fire_go && load_sel[g]),
        .kill   (kill_sel[g]),
        .move   (move_c),
        .load_x (fire_x),
        .load_y (fire_y),
        .hpos   (hpos),
        .vpos   (vpos),
        .active (active_vec[g]),
        .hit_c  (hit_vec[g])
      );
    end
  endgenerate

  // Lowest-index hit wins the pixel; index reads 0 when nothing is hit.
  always_comb begin
    hit_any   = 1'b0;
    gfx_idx_d = '0;
    for (int i = 0; i < int'(N_MISSILES); i++) begin
      if (hit_vec[i] && !hit_any) begin
        hit_any   = 1'b1;
        gfx_idx_d = IDX_W'(i);
      end
    end
    gfx_d = display_on && hit_any;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_ack_q <= 1'b0;
      gfx_q      <= 1'b0;
      gfx_idx_q  <= '0;
    end else begin
      fire_ack_q <= fire_ack_d;
      gfx_q      <= gfx_d;
      gfx_idx_q  <= gfx_idx_d;
    end
  end

  assign fire_ack    = fire_ack_q;
  assign fire_full   = &active_vec;
  assign active_mask = active_vec;
  assign gfx         = gfx_q;
  assign gfx_idx     = gfx_idx_q;

endmodule

// File: doc/missile_array_renderer.md
Name: missile_array_renderer

Overview:
- Parametrised successor to the single fixed missile sprite: holds N independent missiles, each with its own position and active flag.
- Accepts launch requests through a req/ack handshake and moves every active missile upward once per frame.
- Retires missiles that leave the top of the screen or are killed.
- Produces a registered per-pixel graphics bit plus the winning slot index, for the colour mixer beside the hvsync_Generator.

Parameters:
- N_MISSILES, 4, number of missile slots (1..16)
- IDX_W, 2, slot index width; must equal clog2(N_MISSILES), minimum 1
- MISSILE_W, 2, sprite width in pixels (1..16)
- MISSILE_H, 8, sprite height in rows (2..16)
- SPEED, 4, rows moved up per frame (1..15)
- UPDATE_LINE, 240, vpos on which the per-frame motion update occurs

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  9  current pixel column from hvsync_Generator
- vpos  in  9  current scanline from hvsync_Generator
- display_on  in  1  visible-area flag
- fire_req  in  1  launch request; held until fire_ack
- fire_x  in  9  launch column (left edge)
- fire_y  in  9  launch row (top edge)
- fire_ack  out  1  one-cycle pulse: request accepted
- fire_full  out  1  no free slot; combinational from the slot state
- kill_valid  in  1  one-cycle kill strobe
- kill_idx  in  IDX_W  slot to kill
- active_mask  out  N_MISSILES  per-slot active flags
- gfx  out  1  registered pixel-on
- gfx_idx  out  IDX_W  registered index of the lowest-numbered hit slot; 0 when gfx=0

Behaviour:
- Reset (reset=0, asynchronous): all slots inactive; x=0, y=0; fire_ack=0, gfx=0, gfx_idx=0, active_mask=0. fire_full=0 follows from this.
- Reset mid-frame or mid-handshake: everything clears immediately. A pending fire_req is re-evaluated after release.
- Launch:
  - When fire_req=1, fire_ack=0, and at least one slot is free, the lowest-index free slot loads x=fire_x, y=fire_y and becomes active on the next edge.
  - fire_ack=1 for exactly that following cycle. fire_req is ignored while fire_ack=1, so a held request never launches twice.
  - If no slot is free, fire_req waits with no ack and fire_full=1.
- Kill: kill_valid=1 on an active slot clears it next edge. Kill on an inactive slot has no effect. An out-of-range index (>= N_MISSILES) is ignored.
- Kill and fire in the same cycle: the killed slot counts as occupied for that cycle's allocation, so the freed slot is reusable only from the next cycle.
- Frame motion: in the cycle where hpos==0 and vpos==UPDATE_LINE, every active slot updates:
  - if y < SPEED, the slot deactivates;
  - otherwise y <= y - SPEED.
- A slot launched in the motion cycle takes fire_y unmodified; it is not moved that frame.
- Kill and motion on the same slot in the same cycle: the kill wins.
- Hit test, per slot, combinational:
  - active, and
  - hpos in [x, x+MISSILE_W), and
  - vpos in [y+1, y+MISSILE_H).
  - Row y is transparent (the top blank row), matching the existing missile shape.
  - Comparisons use 10-bit sums, so x+W and y+H never wrap. Sprites extending past 511 are clipped, not wrapped.
- Output, latency 1 cycle:
  - gfx <= display_on & (any hit);
  - gfx_idx <= priority-encoded lowest hit index, or 0 when there is no hit.
- active_mask is a direct register view, updated on the same edge as the slot state.

Decomposition:
- Package missile_pkg holds:
  - default geometry constants (MISSILE_W, MISSILE_H, SPEED, UPDATE_LINE);
  - the 9-bit coordinate width constant;
  - a slot struct/typedef {active, x[8:0], y[8:0]}.
- Sub-module missile_slot, one instance per slot via generate:
  - holds the slot registers;
  - applies load/kill/motion with the kill > load > motion priority above;
  - outputs active and a combinational hit.
- The top level holds free-slot allocation, the handshake, the priority encoder and the output registers.

Test Plan:
- Reset then fire_req with x=100, y=200 → fire_ack pulses one cycle later, active_mask=0001, slot 0 at (100,200). With fire_req still held, no second launch occurs.
- Four launches fill all slots, then a fifth fire_req → fire_full=1, no ack. Then kill_idx=2 → next cycle fire_full=0; the following cycle the launch lands in slot 2 and fire_ack pulses.
- Slot at y=200, SPEED=4, one update line → y=196. A slot at y=3 → deactivated on the update line, active_mask bit cleared.
- Slot at (100,200), scan: hpos=100,vpos=200 → gfx=0 (blank row). hpos=100,vpos=201 → gfx=1 one cycle later. hpos=102,vpos=201 → gfx=0. With display_on=0 → gfx=0.
- Slots 1 and 3 overlapping at the same pixel → gfx=1, gfx_idx=1. Then kill slot 1 → gfx_idx=3.
- Assert reset during a fire_ack cycle with two active slots → outputs and active_mask are 0 immediately; after release a held fire_req launches into slot 0.
